// File: rtl/btn_pkg.sv
// Shared types and default timing for the button pulse generator.
package btn_pkg;

   typedef enum logic [1:0] {
      RELEASED     = 2'd0,
      PRESS_WAIT   = 2'd1,
      PRESSED      = 2'd2,
      RELEASE_WAIT = 2'd3
   } btn_state_t;

   localparam int DEF_N_BTN           = 3;
   localparam int DEF_DEBOUNCE_CYCLES = 500000;    // 10 ms at 50 MHz
   localparam int DEF_REPEAT_DELAY    = 25000000;  // 500 ms at 50 MHz
   localparam int DEF_REPEAT_PERIOD   = 5000000;   // 100 ms at 50 MHz

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return m;
   endfunction

   // One spare bit above the largest terminal count keeps saturation clear of it.
   function automatic int cnt_width(input int d, input int r, input int p);
      return $clog2(max3(d, r, p)) + 1;
   endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-flop synchronizer, debounce FSM, press/release pulses.
// Optional auto-repeat of the press pulse is built when BTN_AUTOREPEAT_EN is defined.
module btn_debounce_ch
   import btn_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_n,
   output logic key_level,
   output logic key_press,
   output logic key_release
);

   localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
   localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
`ifdef BTN_AUTOREPEAT_EN
   localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);
`endif

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      if (&v) return v;
      return v + CNT_W'(1);
   endfunction

   logic             sync_p0;
   logic             sync_p1;
   btn_state_t       state_q;
   btn_state_t       state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             press_q;
   logic             press_d;
   logic             release_q;
   logic             release_d;
`ifdef BTN_AUTOREPEAT_EN
   logic             rep_q;
   logic             rep_d;
`endif

   // Synchronizer stage: presets to released so reset never looks like a press.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_p0 <= 1'b1;
         sync_p1 <= 1'b1;
      end else begin
         sync_p0 <= btn_n;
         sync_p1 <= sync_p0;
      end
   end

   // FSM stage: state, counter and registered pulses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= RELEASED;
         cnt_q     <= '0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
         rep_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         press_q   <= press_d;
         release_q <= release_d;
`ifdef BTN_AUTOREPEAT_EN
         rep_q     <= rep_d;
`endif
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = sat_inc(cnt_q);
      press_d   = 1'b0;
      release_d = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
      rep_d     = rep_q;
`endif
      case (state_q)
         RELEASED: begin
            cnt_d = '0;
            if (!sync_p1) state_d = PRESS_WAIT;
         end
         PRESS_WAIT: begin
            if (sync_p1) begin
               state_d = RELEASED;
               cnt_d   = '0;
            end else if (cnt_q == DEB_LAST) begin
               state_d = PRESSED;
               cnt_d   = '0;
               press_d = 1'b1;
`ifdef BTN_AUTOREPEAT_EN
               rep_d   = 1'b0;
`endif
            end
         end
         PRESSED: begin
            if (sync_p1) begin
               state_d = RELEASE_WAIT;
               cnt_d   = '0;
            end else begin
`ifdef BTN_AUTOREPEAT_EN
               // First repeat waits the long delay, later ones the short period.
               if (rep_q ? (cnt_q == PER_LAST) : (cnt_q == DLY_LAST)) begin
                  press_d = 1'b1;
                  cnt_d   = '0;
                  rep_d   = 1'b1;
               end
`else
               cnt_d = '0;
`endif
            end
         end
         RELEASE_WAIT: begin
            if (!sync_p1) begin
               // Bounce on release: fall back to held without a new press pulse.
               state_d = PRESSED;
               cnt_d   = '0;
`ifdef BTN_AUTOREPEAT_EN
               rep_d   = 1'b0;
`endif
            end else if (cnt_q == DEB_LAST) begin
               state_d   = RELEASED;
               cnt_d     = '0;
               release_d = 1'b1;
            end
         end
         default: begin
            state_d = RELEASED;
            cnt_d   = '0;
         end
      endcase
   end

   assign key_press   = press_q;
   assign key_release = release_q;
   assign key_level   = (state_q == PRESSED) || (state_q == RELEASE_WAIT);

endmodule

// File: rtl/btn_pulse_gen.sv
// Multi-channel button debouncer producing level, press and release outputs.
// Auto-repeat of btn_press is compiled in only with BTN_AUTOREPEAT_EN defined.
module btn_pulse_gen
   import btn_pkg::*;
#(
   parameter int N_BTN           = DEF_N_BTN,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_BTN-1:0] btn_n,
   output logic [N_BTN-1:0] btn_level,
   output logic [N_BTN-1:0] btn_press,
   output logic [N_BTN-1:0] btn_release
);

   // Channels share nothing but clock and reset, so presses never arbitrate.
   for (genvar i = 0; i < N_BTN; i++) begin : g_ch
      btn_debounce_ch #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .REPEAT_DELAY    (REPEAT_DELAY),
         .REPEAT_PERIOD   (REPEAT_PERIOD)
      ) u_ch (
         .clk         (clk),
         .rst         (rst),
         .btn_n       (btn_n[i]),
         .key_level   (btn_level[i]),
         .key_press   (btn_press[i]),
         .key_release (btn_release[i])
      );
   end

endmodule

// File: tb/tb_btn_pulse_gen.sv
// Scoreboard bench for btn_pulse_gen with short debounce/repeat timing.
module tb_btn_pulse_gen;

   localparam int DEB = 4;
   localparam int RD  = 10;
   localparam int RP  = 3;
   localparam int LAT = 2 + DEB + 1;
`ifdef BTN_AUTOREPEAT_EN
   localparam bit AR = 1'b1;
`else
   localparam bit AR = 1'b0;
`endif

   typedef struct {
      logic [2:0] press;
      logic [2:0] rel;
      logic [2:0] lvl;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] btn_n;
   logic [2:0] btn_level;
   logic [2:0] btn_press;
   logic [2:0] btn_release;

   int   n_chk  = 0;
   int   n_fail = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   btn_pulse_gen #(
      .N_BTN           (3),
      .DEBOUNCE_CYCLES (DEB),
      .REPEAT_DELAY    (RD),
      .REPEAT_PERIOD   (RP)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .btn_n       (btn_n),
      .btn_level   (btn_level),
      .btn_press   (btn_press),
      .btn_release (btn_release)
   );

   task automatic chk(input string tag, input logic [2:0] got, input logic [2:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %b, expected %b", tag, $time, got, exp);
      end
   endtask

   function automatic exp_t mk(input logic [2:0] p, input logic [2:0] r, input logic [2:0] l);
      exp_t e;
      e.press = p;
      e.rel   = r;
      e.lvl   = l;
      return e;
   endfunction

   // Repeat pulses land at LAT+RD, then every RP cycles, counted from the pin edge.
   function automatic bit rep_due(input int c);
      return AR && (c >= LAT + RD) && (((c - LAT - RD) % RP) == 0);
   endfunction

   // Drive one cycle of stimulus, queue the response expected next cycle, then check it.
   task automatic tick(input string tag, input logic r, input logic [2:0] b, input exp_t e);
      exp_t x;
      rst   = r;
      btn_n = b;
      sb.push_back(e);
      @(negedge clk);
      x = sb.pop_front();
      chk({tag, "/press"},   btn_press,   x.press);
      chk({tag, "/release"}, btn_release, x.rel);
      chk({tag, "/level"},   btn_level,   x.lvl);
      chk({tag, "/excl"},    btn_press & btn_release, 3'b000);
   endtask

   task automatic idle(input string tag, input int n);
      for (int k = 0; k < n; k++) tick(tag, 1'b0, 3'b111, mk(3'b000, 3'b000, 3'b000));
   endtask

   // Hold keys in mask for 'hold' cycles, then release them and watch for the release pulse.
   task automatic run_press(input string tag, input logic [2:0] mask, input int hold);
      int   c;
      exp_t e;
      for (int k = 0; k < hold; k++) begin
         c = k + 1;
         e = mk(((c == LAT) || rep_due(c)) ? mask : 3'b000, 3'b000,
                (c >= LAT) ? mask : 3'b000);
         tick(tag, 1'b0, ~mask, e);
      end
      for (int r = 0; r < 10; r++) begin
         c = hold + r + 1;
         e = mk(((c <= hold + 2) && rep_due(c)) ? mask : 3'b000,
                (r + 1 == LAT) ? mask : 3'b000,
                (r + 1 < LAT) ? mask : 3'b000);
         tick(tag, 1'b0, 3'b111, e);
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t zero;
      zero  = mk(3'b000, 3'b000, 3'b000);
      rst   = 1'b0;
      btn_n = 3'b111;
      #2 rst = 1'b1;
      @(negedge clk);

      repeat (3) tick("reset", 1'b1, 3'b111, zero);
      idle("idle0", 4);

      run_press("ch0", 3'b001, 12);
      idle("idle1", 3);

      for (int k = 0; k < 30; k++)
         tick("bounce", 1'b0, (k < 20 && ((k / 2) % 2 == 0)) ? 3'b101 : 3'b111, zero);

      run_press("ch2_hold", 3'b100, LAT + 30);
      idle("idle2", 3);

      repeat (3) tick("rst_held", 1'b1, 3'b000, zero);
      run_press("all_held", 3'b111, 12);
      idle("idle3", 3);

      for (int k = 0; k < 5; k++) tick("abort", 1'b0, 3'b110, zero);
      tick("abort_rst", 1'b1, 3'b111, zero);
      tick("abort_rst", 1'b1, 3'b111, zero);
      repeat (12) tick("abort_after", 1'b0, 3'b111, zero);

      for (int k = 0; k < 9; k++)
         tick("rst_pressed", 1'b0, 3'b101,
              mk((k + 1 == LAT) ? 3'b010 : 3'b000, 3'b000,
                 (k + 1 >= LAT) ? 3'b010 : 3'b000));
      rst = 1'b1;
      #1;
      chk("rst_imm/level",   btn_level,   3'b000);
      chk("rst_imm/press",   btn_press,   3'b000);
      chk("rst_imm/release", btn_release, 3'b000);
      tick("rst_pressed_rst", 1'b1, 3'b111, zero);
      repeat (12) tick("rst_pressed_after", 1'b0, 3'b111, zero);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
